// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    // Access sequencing: sample, strobe memory, wait out read latency, respond.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    // Owner of the in-flight access; also the encoding of the last grant.
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    // Supported memory read latency range, in cycles.
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    // Data port
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    // Pipeline freeze
    logic              stall_if;
    logic              stall_mem;
    // Memory macro
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Pipeline and memory side
    modport master (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one fixed-latency
// memory port. Data wins a conflict unless it won the previous grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_grant_q;
    logic              owner_q;
    logic              is_wr_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_ready_q;
    logic              d_ready_q;

    logic              data_pend;
    logic              grant_any;
    logic              grant_data;
    logic              grant_wr;
    logic [ADDR_W-1:0] grant_addr;

    // Arbitration decision for the IDLE state; rd+wr together counts as a write.
    always_comb begin
        data_pend       = bus.d_rd | bus.d_wr;
        grant_any       = data_pend | bus.if_req;
        grant_data      = data_pend & (~bus.if_req | (last_grant_q != OWN_DATA));
        grant_wr        = grant_data & bus.d_wr;
        grant_addr      = grant_data ? bus.d_addr : bus.if_addr;
        grant_addr[1:0] = 2'b00;
    end

    // Stalls are gated by reset so every output reads 0 while reset is held.
    assign bus.stall_if  = bus.if_req & ~if_ready_q & ~reset;
    assign bus.stall_mem = data_pend & ~d_ready_q & ~reset;

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;

    // Access FSM with registered memory strobes, read capture and ready pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= OWN_FETCH;
            owner_q      <= OWN_FETCH;
            is_wr_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        state_q      <= ISSUE;
                        owner_q      <= grant_data ? OWN_DATA : OWN_FETCH;
                        last_grant_q <= grant_data ? OWN_DATA : OWN_FETCH;
                        is_wr_q      <= grant_wr;
                        mem_en_q     <= 1'b1;
                        mem_we_q     <= grant_wr;
                        mem_addr_q   <= grant_addr;
                        mem_wdata_q  <= grant_wr ? bus.d_wdata : '0;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (is_wr_q) begin
                        // Only the data port ever writes.
                        state_q   <= RESP;
                        d_ready_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_W'(MEM_LAT);
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                        cnt_q   <= '0;
                        if (owner_q == OWN_DATA) begin
                            d_rdata_q <= bus.mem_rdata;
                            d_ready_q <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.mem_rdata;
                            if_ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    // No grant here: requesters get one edge to drop or change.
                    state_q    <= IDLE;
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration and memory contents.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int          L       = MEM_LAT;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .MEM_LAT(MEM_LAT),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory macro model: 64 words aliased over the address space, reloaded on reset.
    logic [31:0] dev_mem [64];
    logic [31:0] rd_pipe [MEM_LAT];

    function automatic logic [31:0] init_word(input logic [5:0] idx);
        if (idx == 6'd1) return 32'h2402_0005;
        return 32'h5A00_0000 | {18'h0, idx, 8'h00} | {26'h0, idx};
    endfunction

    // Read data appears exactly MEM_LAT cycles after the mem_en cycle; junk otherwise.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) dev_mem[i] <= init_word(6'(i));
        end else if (bus.mem_en && bus.mem_we) begin
            dev_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? dev_mem[bus.mem_addr[7:2]] : $urandom;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic set_idle();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_rd    = 1'b0;
        bus.d_wr    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bit got;
        reset = 1'b1;
        set_idle();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_2012;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.if_ready, bus.d_ready, bus.stall_if, bus.stall_mem, bus.mem_en,
                 bus.mem_we} !== 6'b0 || bus.if_rdata !== '0 || bus.d_rdata !== '0 ||
                bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
                n_err++;
                $display("FAIL reset_outputs c%0d: rdy=%b%b stall=%b%b en/we=%b%b addr=%h wd=%h ifr=%h dr=%h, want all 0",
                         i, bus.if_ready, bus.d_ready, bus.stall_if, bus.stall_mem, bus.mem_en,
                         bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata);
            end
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.mem_en !== 1'b0 || bus.stall_if !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: mem_en=%b stall_if=%b, want 0 1", bus.mem_en, bus.stall_if);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h0000_2010) begin
            n_err++;
            $display("FAIL first_issue: mem_en=%b addr=%h, want 1 00002010", bus.mem_en, bus.mem_addr);
        end
        got = 1'b0;
        for (int n = 0; n < 16 && !got; n++) begin
            @(negedge clk);
            got = (bus.if_ready === 1'b1);
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL first_fetch_ready: no if_ready within 16 cycles, want a pulse");
        end else if (bus.if_rdata !== init_word(6'd4)) begin
            n_err++;
            $display("FAIL first_fetch_data: if_rdata=%h, want %h", bus.if_rdata, init_word(6'd4));
        end
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch_read();
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0040_0006;
        #1;
        n_cmp++;
        if (bus.stall_if !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_stall c0: stall_if=%b, want 1", bus.stall_if);
        end
        for (int n = 1; n <= L + 3; n++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.mem_en !== (n == 1) || (n == 1 && (bus.mem_addr !== 32'h0040_0004 ||
                bus.mem_we !== 1'b0))) begin
                n_err++;
                $display("FAIL fetch_issue c%0d: en=%b we=%b addr=%h, want en=%b addr 00400004",
                         n, bus.mem_en, bus.mem_we, bus.mem_addr, n == 1);
            end
            n_cmp++;
            if (bus.if_ready !== (n == L + 2) || bus.stall_if !== (n < L + 2)) begin
                n_err++;
                $display("FAIL fetch_ready c%0d: if_ready=%b stall_if=%b, want %b %b",
                         n, bus.if_ready, bus.stall_if, n == L + 2, n < L + 2);
            end
            if (n == L + 2) begin
                n_cmp++;
                if (bus.if_rdata !== 32'h2402_0005) begin
                    n_err++;
                    $display("FAIL fetch_data: if_rdata=%h, want 24020005", bus.if_rdata);
                end
                bus.if_req = 1'b0;
            end
        end
        n_cmp++;
        if (bus.if_rdata !== 32'h2402_0005) begin
            n_err++;
            $display("FAIL fetch_data_hold: if_rdata=%h, want 24020005", bus.if_rdata);
        end
    endtask

    task automatic test_store();
        bus.d_wr    = 1'b1;
        bus.d_addr  = 32'h1000_0008;
        bus.d_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (bus.stall_mem !== 1'b1) begin
            n_err++;
            $display("FAIL store_stall c0: stall_mem=%b, want 1", bus.stall_mem);
        end
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.mem_en !== (n == 1) || bus.mem_we !== (n == 1) ||
                (n == 1 && (bus.mem_addr !== 32'h1000_0008 || bus.mem_wdata !== 32'hDEAD_BEEF))) begin
                n_err++;
                $display("FAIL store_issue c%0d: en=%b we=%b addr=%h wd=%h, want en=we=%b 10000008 deadbeef",
                         n, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, n == 1);
            end
            n_cmp++;
            if (bus.d_ready !== (n == 2) || bus.stall_mem !== (n < 2)) begin
                n_err++;
                $display("FAIL store_ready c%0d: d_ready=%b stall_mem=%b, want %b %b",
                         n, bus.d_ready, bus.stall_mem, n == 2, n < 2);
            end
            if (n == 2) bus.d_wr = 1'b0;
        end
    endtask

    // Data wins the first conflict, then a re-raised data request loses to fetch.
    task automatic test_conflict();
        logic [31:0] a, b, c, exp_addr;
        bit          exp_en;
        a = 32'h2000_0020;
        b = 32'h0000_2030;
        c = 32'h0000_2044;
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        bus.d_rd    = 1'b1;
        bus.d_addr  = b;
        for (int n = 1; n <= 9 + 3 * L; n++) begin
            @(negedge clk);
            exp_en   = (n == 1) || (n == 4 + L) || (n == 7 + 2 * L);
            exp_addr = (n == 1) ? b : (n == 4 + L) ? a : c;
            n_cmp++;
            if (bus.mem_en !== exp_en || (exp_en && bus.mem_addr !== exp_addr)) begin
                n_err++;
                $display("FAIL conflict_issue c%0d: en=%b addr=%h, want en=%b addr=%h",
                         n, bus.mem_en, bus.mem_addr, exp_en, exp_addr);
            end
            n_cmp++;
            if (bus.if_ready !== (n == 5 + 2 * L) ||
                bus.d_ready !== (n == 2 + L || n == 8 + 3 * L)) begin
                n_err++;
                $display("FAIL conflict_ready c%0d: if_ready=%b d_ready=%b, want %b %b", n,
                         bus.if_ready, bus.d_ready, n == 5 + 2 * L, n == 2 + L || n == 8 + 3 * L);
            end
            n_cmp++;
            if (bus.stall_if !== (n < 5 + 2 * L) ||
                bus.stall_mem !== (n < 8 + 3 * L && n != 2 + L)) begin
                n_err++;
                $display("FAIL conflict_stall c%0d: stall_if=%b stall_mem=%b, want %b %b", n,
                         bus.stall_if, bus.stall_mem, n < 5 + 2 * L, n < 8 + 3 * L && n != 2 + L);
            end
            if (n == 2 + L) begin
                n_cmp++;
                if (bus.d_rdata !== init_word(b[7:2])) begin
                    n_err++;
                    $display("FAIL conflict_data1: d_rdata=%h, want %h", bus.d_rdata, init_word(b[7:2]));
                end
                bus.d_addr = c;
            end
            if (n == 5 + 2 * L) begin
                n_cmp++;
                if (bus.if_rdata !== init_word(a[7:2])) begin
                    n_err++;
                    $display("FAIL conflict_fetch: if_rdata=%h, want %h", bus.if_rdata, init_word(a[7:2]));
                end
                bus.if_req = 1'b0;
            end
            if (n == 8 + 3 * L) begin
                n_cmp++;
                if (bus.d_rdata !== init_word(c[7:2])) begin
                    n_err++;
                    $display("FAIL conflict_data2: d_rdata=%h, want %h", bus.d_rdata, init_word(c[7:2]));
                end
                bus.d_rd = 1'b0;
            end
        end
    endtask

    task automatic test_rd_wr_both();
        bit got;
        do_reset();
        bus.d_rd   = 1'b1;
        bus.d_addr = 32'h0000_2010;
        got = 1'b0;
        for (int n = 0; n < 16 && !got; n++) begin
            @(negedge clk);
            got = (bus.d_ready === 1'b1);
        end
        n_cmp++;
        if (!got || bus.d_rdata !== init_word(6'd4)) begin
            n_err++;
            $display("FAIL both_preload: ready=%b d_rdata=%h, want 1 %h", got, bus.d_rdata, init_word(6'd4));
        end
        bus.d_wr    = 1'b1;
        bus.d_wdata = 32'h0000_00FF;
        @(negedge clk);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.mem_en !== (n == 1) || bus.mem_we !== (n == 1) ||
                (n == 1 && (bus.mem_wdata !== 32'h0000_00FF || bus.mem_addr !== 32'h0000_2010))) begin
                n_err++;
                $display("FAIL both_issue c%0d: en=%b we=%b addr=%h wd=%h, want en=we=%b 00002010 000000ff",
                         n, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, n == 1);
            end
            n_cmp++;
            if (bus.d_ready !== (n == 2) || bus.d_rdata !== init_word(6'd4)) begin
                n_err++;
                $display("FAIL both_ready c%0d: d_ready=%b d_rdata=%h, want %b %h",
                         n, bus.d_ready, bus.d_rdata, n == 2, init_word(6'd4));
            end
            if (n == 2) bus.d_wr = 1'b0;
        end
        got = 1'b0;
        for (int n = 0; n < 16 && !got; n++) begin
            @(negedge clk);
            got = (bus.d_ready === 1'b1);
        end
        n_cmp++;
        if (!got || bus.d_rdata !== 32'h0000_00FF) begin
            n_err++;
            $display("FAIL both_readback: ready=%b d_rdata=%h, want 1 000000ff", got, bus.d_rdata);
        end
        bus.d_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_2024;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.mem_en !== 1'b0 || bus.if_ready !== 1'b0 || bus.if_rdata !== '0) begin
            n_err++;
            $display("FAIL midread_reset: en=%b if_ready=%b if_rdata=%h, want 0 0 0",
                     bus.mem_en, bus.if_ready, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < L + 4; n++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.if_ready !== 1'b0 || bus.d_ready !== 1'b0 || bus.mem_en !== 1'b0) begin
                n_err++;
                $display("FAIL midread_noready c%0d: if_ready=%b d_ready=%b en=%b, want 0 0 0",
                         n, bus.if_ready, bus.d_ready, bus.mem_en);
            end
        end
        // Reset while the strobe itself is up must drop it without waiting for a clock.
        bus.d_wr    = 1'b1;
        bus.d_addr  = 32'h0000_2028;
        bus.d_wdata = 32'h1234_5678;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL issue_reset_async: en=%b we=%b, want 0 0", bus.mem_en, bus.mem_we);
        end
        bus.d_wr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.d_ready !== 1'b0 || bus.mem_en !== 1'b0) begin
                n_err++;
                $display("FAIL issue_reset_noready c%0d: d_ready=%b en=%b, want 0 0",
                         n, bus.d_ready, bus.mem_en);
            end
        end
    endtask

    // Random requesters against a transaction model: grant order from the priority
    // rule, completion times from the access latencies, data from a reference memory.
    task automatic test_random();
        logic [31:0] ref_mem [64];
        logic [31:0] f_addr, dd_addr, dd_wdata, m_addr, m_wdata, m_rdata;
        logic [31:0] m_if_rdata, m_d_rdata;
        bit          f_act, d_act, d_rd_v, d_wr_v;
        bit          m_busy, m_own_data, m_wr, m_last_data;
        bit          exp_en, exp_ifr, exp_dr;
        int          m_issue, m_ready, m_idle_from, kind;
        do_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(6'(i));
        f_act = 0; d_act = 0; d_rd_v = 0; d_wr_v = 0;
        f_addr = '0; dd_addr = '0; dd_wdata = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        m_if_rdata = '0; m_d_rdata = '0;
        m_busy = 0; m_own_data = 0; m_wr = 0; m_last_data = 0;
        m_issue = -1; m_ready = -1; m_idle_from = 0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge clk);
            exp_en  = m_busy && (c == m_issue);
            exp_ifr = m_busy && (c == m_ready) && !m_own_data;
            exp_dr  = m_busy && (c == m_ready) && m_own_data;
            if (exp_ifr) m_if_rdata = m_rdata;
            if (exp_dr && !m_wr) m_d_rdata = m_rdata;
            n_cmp++;
            if (bus.mem_en !== exp_en || bus.mem_we !== (exp_en && m_wr) ||
                (exp_en && bus.mem_addr !== {m_addr[31:2], 2'b00}) ||
                (exp_en && m_wr && bus.mem_wdata !== m_wdata)) begin
                n_err++;
                $display("FAIL rnd_mem c%0d: en=%b we=%b addr=%h wd=%h, want en=%b we=%b addr=%h wd=%h",
                         c, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_en,
                         exp_en && m_wr, {m_addr[31:2], 2'b00}, m_wdata);
            end
            n_cmp++;
            if (bus.if_ready !== exp_ifr || bus.d_ready !== exp_dr) begin
                n_err++;
                $display("FAIL rnd_ready c%0d: if_ready=%b d_ready=%b, want %b %b",
                         c, bus.if_ready, bus.d_ready, exp_ifr, exp_dr);
            end
            n_cmp++;
            if (bus.if_rdata !== m_if_rdata || bus.d_rdata !== m_d_rdata) begin
                n_err++;
                $display("FAIL rnd_rdata c%0d: if_rdata=%h d_rdata=%h, want %h %h",
                         c, bus.if_rdata, bus.d_rdata, m_if_rdata, m_d_rdata);
            end
            n_cmp++;
            if (bus.stall_if !== (f_act && !exp_ifr) || bus.stall_mem !== (d_act && !exp_dr)) begin
                n_err++;
                $display("FAIL rnd_stall c%0d: stall_if=%b stall_mem=%b, want %b %b",
                         c, bus.stall_if, bus.stall_mem, f_act && !exp_ifr, d_act && !exp_dr);
            end
            if (m_busy && c == m_ready) begin
                m_busy      = 0;
                m_idle_from = c + 1;
            end
            if (exp_ifr) f_act = 0;
            if (exp_dr) d_act = 0;
            if (!f_act && $urandom_range(0, 2) == 0) begin
                f_act  = 1;
                f_addr = 32'h0000_2000 | 32'($urandom_range(0, 255));
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act    = 1;
                kind     = int'($urandom_range(0, 2));
                d_rd_v   = (kind != 1);
                d_wr_v   = (kind != 0);
                dd_addr  = 32'h0000_2000 | 32'($urandom_range(0, 255));
                dd_wdata = $urandom;
            end
            bus.if_req  = f_act;
            bus.if_addr = f_addr;
            bus.d_rd    = d_act && d_rd_v;
            bus.d_wr    = d_act && d_wr_v;
            bus.d_addr  = dd_addr;
            bus.d_wdata = dd_wdata;
            if (!m_busy && c >= m_idle_from && (f_act || d_act)) begin
                m_own_data  = d_act && (!f_act || !m_last_data);
                m_last_data = m_own_data;
                m_wr        = m_own_data && d_wr_v;
                m_addr      = m_own_data ? dd_addr : f_addr;
                m_wdata     = dd_wdata;
                m_issue     = c + 1;
                m_ready     = c + 2 + (m_wr ? 0 : L);
                m_busy      = 1;
                if (m_wr) ref_mem[m_addr[7:2]] = m_wdata;
                else m_rdata = ref_mem[m_addr[7:2]];
            end
        end
        set_idle();
        repeat (L + 4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_store();
        test_conflict();
        test_rd_wr_both();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, want completion before 200000");
        $fatal(1);
    end

endmodule
